alu_sched: RTL and testbench
============================

// Module: alu_sched
// PURPOSE
//  Sequencer/arbiter that shares one combinational 4-bit ALU (3-bit opcode, operands a/b) among NREQ requesters.
//  Accepts one operation at a time via valid/ready and grants requesters round-robin.
//  Drives the ALU from registered operands, captures the result after ALU_LAT cycles, returns it tagged with requester id.
//  Sits between client blocks and the shared alu instance; the alu itself stays outside this module.
// PARAMETERS
//  NREQ     2   number of requesters (>=1)
//  W        4   operand/result width
//  OCW      3   opcode width
//  ALU_LAT  1   cycles operands are held before result capture (>=1)
//  IDW      = (NREQ>1) ? $clog2(NREQ) : 1; localparam, response id width
// PORTS
//  clk        in   1         clock; all state on rising edge
//  rst        in   1         synchronous reset, active-high
//  req_valid  in   NREQ      per-requester request valid
//  req_ready  out  NREQ      per-requester accept; one-hot or zero
//  req_oc     in   NREQ*OCW  packed opcodes; requester i at [i*OCW +: OCW]
//  req_a      in   NREQ*W    packed operand a
//  req_b      in   NREQ*W    packed operand b
//  alu_oc     out  OCW       to ALU opcode
//  alu_a      out  W         to ALU operand a
//  alu_b      out  W         to ALU operand b
//  alu_out    in   W         ALU result (combinational from alu_oc/a/b)
//  rsp_valid  out  1         response valid
//  rsp_ready  in   1         response accept
//  rsp_id     out  IDW       index of the requester that issued the op
//  rsp_data   out  W         captured ALU result
//  op_count   out  16        completed-op counter (see CONFIGURATION)
// BEHAVIOUR
//  Clock is clk; reset rst is synchronous and active-high. Reset: state IDLE; rsp_valid, rsp_id, rsp_data, alu_* = 0;
//    rr pointer = NREQ-1, so requester 0 wins first; op_count = 0.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//  IDLE: if any req_valid, req_ready[g]=1 combinationally for the rr winner g only.
//    g = first valid index after the pointer, wrapping.
//    Handshake (valid&ready) latches oc/a/b/id, sets pointer=g, goes to EXEC. alu_* = 0 in IDLE.
//  EXEC: alu_* driven from latched regs, stable for ALU_LAT cycles. Capture alu_out into rsp_data on the last EXEC cycle; go to RESP.
//  RESP: rsp_valid=1 with rsp_id/rsp_data stable until rsp_ready=1. alu_* keep latched values. No req_ready asserted.
//    rsp_valid&rsp_ready -> IDLE.
//  Timing: handshake at cycle t -> rsp_valid first high at t+ALU_LAT+1; earliest next handshake t+ALU_LAT+2.
//  req_valid deassert without handshake: no effect, no grant recorded. Requests are never dropped once accepted.
//  Width: data passes through unmodified, W bits; no carry/overflow generated here.
//  rst asserted in any state: in-flight op discarded, no response emitted, next cycle behaves as post-reset.
// CONFIGURATION
//  `ALU_SCHED_STATS_EN defined: op_count increments on each rsp_valid&rsp_ready, wraps 16'hFFFF->0.
//  Not defined: op_count tied to 16'd0, no counter flops.
// STRUCTURE
//  Package alu_sched_pkg: state enum (IDLE/EXEC/RESP), ALU_W=4, ALU_OCW=3 constants.
//  Sub-module rr_arbiter (NREQ): req vector + pointer in, one-hot grant + index out, combinational.
//  Latency counter ($clog2(ALU_LAT+1) bits) and datapath regs in alu_sched.
// TESTING (bench instantiates the real alu; expected = alu model on same inputs; NREQ=2, ALU_LAT=1)
//  1 req0 oc=0,a=5,b=3 pulse -> req_ready[0] same cycle; rsp_valid at t+2, rsp_id=0, rsp_data=alu(0,5,3).
//  2 both req_valid held for 6 ops, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1; one handshake per 3 cycles.
//  3 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/id/data stable; req_ready=0 throughout; on release -> IDLE.
//  4 rst pulsed during EXEC -> no rsp_valid appears; all outputs 0 next cycle; next grant goes to requester 0.
//  5 sweep {oc,a,b}=0..2047 through requester 1 -> all 2048 rsp_data match alu model, rsp_id=1.
//  6 with `ALU_SCHED_STATS_EN: 10 completed ops -> op_count=10; without macro -> op_count=0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared types and constants for the ALU scheduler slice.
//   state_e  - scheduler FSM state (IDLE -> EXEC -> RESP -> IDLE)
//   ALU_W    - default operand/result width of the shared ALU
//   ALU_OCW  - default opcode width of the shared ALU
//   id_width - response id width for a given requester count
package alu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int ALU_W   = 4;
  localparam int ALU_OCW = 3;

  // A single requester still gets a 1-bit id so that no port collapses to zero width.
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: bundle of all request, ALU and response signals of alu_sched.
//   req_valid/req_ready/req_oc/req_a/req_b - per-requester request channel (packed, requester i at slice i)
//   alu_oc/alu_a/alu_b/alu_out             - link to the external combinational ALU
//   rsp_valid/rsp_ready/rsp_id/rsp_data    - single response channel
//   op_count                               - completed-operation counter
//   state                                  - FSM state, debug visibility only
// Modports: slave = the scheduler, master = clients plus the ALU.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. A source keeps valid and its payload stable until that edge; ready may
// depend combinationally on valid (req_ready does), valid never depends on ready.
interface alu_sched_if
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = ALU_W,
  parameter int OCW  = ALU_OCW
) ();

  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OCW-1:0] req_oc;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [OCW-1:0]      alu_oc;
  logic [W-1:0]        alu_a;
  logic [W-1:0]        alu_b;
  logic [W-1:0]        alu_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_data;
  logic [15:0]         op_count;
  state_e              state;

  modport slave (
    input  req_valid, req_oc, req_a, req_b, alu_out, rsp_ready,
    output req_ready, alu_oc, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, op_count, state
  );

  modport master (
    output req_valid, req_oc, req_a, req_b, alu_out, rsp_ready,
    input  req_ready, alu_oc, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, op_count, state
  );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i - request vector
//   ptr_i - index of the last granted requester
//   gnt_o - one-hot grant (zero when no request)
//   idx_o - index of the granted requester
//   any_o - high when some request is granted
// The search starts one past ptr_i and wraps, so the last winner has lowest priority.
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[c]) begin
        gnt_o[c] = 1'b1;
        idx_o    = IDW'(c);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one external combinational ALU among NREQ requesters.
// One operation is in flight at a time: a round-robin winner is accepted in IDLE,
// its operands drive the ALU for ALU_LAT cycles (EXEC), and the captured result is
// offered on the response channel tagged with the requester index (RESP).
//   clk - clock, all state on the rising edge
//   rst - synchronous reset, active-high
//   bus - alu_sched_if.slave carrying request, ALU, response, op_count and state
// Optional build macro: ALU_SCHED_STATS_EN enables the 16-bit completed-op counter;
// without it op_count is constant zero and no counter flops exist.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = ALU_W,
  parameter int OCW     = ALU_OCW,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  alu_sched_if.slave bus
);

  localparam int IDW  = id_width(NREQ);
  localparam int LATW = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [LATW-1:0] LAT_LAST = LATW'(ALU_LAT - 1);

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [LATW-1:0] lat_q;
  logic [OCW-1:0]  oc_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [IDW-1:0]  id_q;
  logic            rsp_valid_q;
  logic [W-1:0]    rsp_data_q;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            req_hs;
  logic [OCW-1:0]  sel_oc;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Grants are only offered while idle; a dropped request leaves the pointer untouched.
  assign bus.req_ready = (state_q == S_IDLE) ? gnt : '0;
  assign req_hs        = (state_q == S_IDLE) && gnt_any;

  assign sel_oc = bus.req_oc[int'(gnt_idx)*OCW +: OCW];
  assign sel_a  = bus.req_a[int'(gnt_idx)*W +: W];
  assign sel_b  = bus.req_b[int'(gnt_idx)*W +: W];

  // Operand registers double as the ALU drive: zero while idle, held through EXEC and RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      lat_q       <= '0;
      oc_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_hs) begin
            oc_q    <= sel_oc;
            a_q     <= sel_a;
            b_q     <= sel_b;
            id_q    <= gnt_idx;
            ptr_q   <= gnt_idx;
            lat_q   <= '0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (lat_q == LAT_LAST) begin
            rsp_data_q  <= bus.alu_out;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            oc_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.alu_oc    = oc_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.state     = state_q;

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] op_count_q;

  // Counts accepted responses; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= '0;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign bus.op_count = op_count_q;
`else
  assign bus.op_count = 16'd0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed bench for alu_sched with NREQ=2, W=4, OCW=3, ALU_LAT=1.
// A behavioural ALU closes the alu_* loop; a negedge monitor pushes the expected
// result on every request handshake and pops/compares on every response handshake.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int W    = 4;
  localparam int OCW  = 3;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;
  int   done_cnt;

  logic [W-1:0] exp_q[$];
  int           exp_id_q[$];
  int           grant_log[$];
  int           hs_cyc[$];

  alu_sched_if #(.NREQ(NREQ), .W(W), .OCW(OCW)) bus ();

  alu_sched #(.NREQ(NREQ), .W(W), .OCW(OCW), .ALU_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [W-1:0] alu_f(input logic [OCW-1:0] oc, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (oc)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  // Shared ALU sitting outside the scheduler.
  assign bus.alu_out = alu_f(bus.alu_oc, bus.alu_a, bus.alu_b);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    int g;
    logic [W-1:0] d;
    int id;
    if (rst) begin
      exp_q.delete();
      exp_id_q.delete();
      done_cnt = 0;
    end else begin
      if (|bus.req_valid) check("ready_onehot", ($countones(bus.req_ready) <= 1), 1);
      if (|(bus.req_valid & bus.req_ready)) begin
        g = bus.req_ready[1] ? 1 : 0;
        exp_q.push_back(alu_f(bus.req_oc[g*OCW +: OCW], bus.req_a[g*W +: W], bus.req_b[g*W +: W]));
        exp_id_q.push_back(g);
        grant_log.push_back(g);
        hs_cyc.push_back(cyc);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rsp_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          d  = exp_q.pop_front();
          id = exp_id_q.pop_front();
          check("rsp_data", bus.rsp_data, d);
          check("rsp_id", bus.rsp_id, id);
        end
        done_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic [OCW-1:0] oc, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    bus.req_oc[idx*OCW +: OCW] = oc;
    bus.req_a[idx*W +: W]      = a;
    bus.req_b[idx*W +: W]      = b;
  endtask

  // Waits (bounded) at negedges for req_ready[idx]; ok=0 on timeout.
  task automatic wait_ready(input int idx, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) begin
        ok = 1'b1;
        return;
      end
    end
    check("ready_timeout", bus.req_ready[idx], 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_rsp_data"}, bus.rsp_data, 0);
    check({tag, "_alu_oc"}, bus.alu_oc, 0);
    check({tag, "_alu_a"}, bus.alu_a, 0);
    check({tag, "_alu_b"}, bus.alu_b, 0);
    check({tag, "_state"}, bus.state, S_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    int base;
    logic [15:0] exp_cnt;
    tests = 0;
    fails = 0;
    done_cnt = 0;
    bus.req_oc = '0;
    bus.req_a  = '0;
    bus.req_b  = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_op_count", bus.op_count, 0);

    // 1: single request from requester 0
    tick();
    set_req(0, 3'd0, 4'd5, 4'd3);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("t1_ready_same_cycle", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t1_exec_alu_a", bus.alu_a, 5);
    check("t1_exec_alu_b", bus.alu_b, 3);
    check("t1_exec_no_rsp", bus.rsp_valid, 0);
    tick();
    @(negedge clk);
    check("t1_rsp_valid_t2", bus.rsp_valid, 1);
    check("t1_rsp_id", bus.rsp_id, 0);
    check("t1_rsp_data", bus.rsp_data, 4'd8);
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check_idle_outputs_partial: begin
      check("t1_back_idle", bus.state, S_IDLE);
      check("t1_idle_alu_a", bus.alu_a, 0);
      check("t1_idle_rsp_valid", bus.rsp_valid, 0);
    end

    // 2: both requesters held, six ops, alternating from requester 0
    do_reset();
    grant_log.delete();
    hs_cyc.delete();
    set_req(0, 3'd1, 4'd9, 4'd2);
    set_req(1, 3'd4, 4'd6, 4'd3);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b11;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (grant_log.size() >= 6) break;
    end
    bus.req_valid = 2'b00;
    check("t2_handshakes", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      check("t2_grant_order", grant_log[i], i % 2);
      if (i > 0) check("t2_hs_spacing", hs_cyc[i] - hs_cyc[i-1], 3);
    end
    repeat (4) tick();
    check("t2_drained", exp_q.size(), 0);

    // 3: response back-pressure for 5 cycles
    bus.rsp_ready = 1'b0;
    set_req(0, 3'd2, 4'hC, 4'hA);
    set_req(1, 3'd3, 4'h5, 4'hA);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("t3_ready0", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b10;
    @(negedge clk);
    check("t3_exec_no_ready", bus.req_ready, 0);
    tick();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("t3_hold_valid", bus.rsp_valid, 1);
      check("t3_hold_id", bus.rsp_id, 0);
      check("t3_hold_data", bus.rsp_data, 4'h8);
      check("t3_hold_no_ready", bus.req_ready, 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("t3_release_idle", bus.state, S_IDLE);
    check("t3_next_grant1", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    repeat (4) tick();
    check("t3_drained", exp_q.size(), 0);

    // 4: reset during EXEC discards the op
    set_req(0, 3'd0, 4'd7, 4'd7);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_ready0", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t4_in_exec", bus.state, S_EXEC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t4_post_rst");
    for (int n = 0; n < 4; n++) begin
      tick();
      @(negedge clk);
      check("t4_no_rsp", bus.rsp_valid, 0);
    end
    tick();
    set_req(0, 3'd5, 4'd3, 4'd0);
    set_req(1, 3'd6, 4'd3, 4'd0);
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("t4_first_grant0", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    repeat (4) tick();
    check("t4_done", done_cnt, 1);

    // 5: full {oc,a,b} sweep through requester 1
    base = done_cnt;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      set_req(1, i[10:8], i[7:4], i[3:0]);
      bus.req_valid = 2'b10;
      wait_ready(1, ok);
      if (!ok) break;
      tick();
    end
    bus.req_valid = 2'b00;
    repeat (4) tick();
    check("t5_rsp_count", done_cnt - base, 2048);
    check("t5_drained", exp_q.size(), 0);
`ifdef ALU_SCHED_STATS_EN
    exp_cnt = done_cnt[15:0];
`else
    exp_cnt = 16'd0;
`endif
    check("t5_op_count", bus.op_count, exp_cnt);

    // 6: op counter after ten completed ops
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      bus.req_valid = 2'b01;
      wait_ready(0, ok);
      if (!ok) break;
      tick();
    end
    bus.req_valid = 2'b00;
    repeat (4) tick();
    check("t6_done", done_cnt, 10);
`ifdef ALU_SCHED_STATS_EN
    exp_cnt = 16'd10;
`else
    exp_cnt = 16'd0;
`endif
    @(negedge clk);
    check("t6_op_count", bus.op_count, exp_cnt);
    check("t6_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
